// File: rtl/pwm_capture.sv
// pwm_capture: recovers the N-bit duty value from a frame-periodic PWM line.
// Each frame is 2^N clocks and the line is high for the first `duty` clocks.
// The block synchronises pwm_in, aligns to the frame-start rising edge,
// counts high clocks per frame and offers one sample per frame on a
// valid/ready handshake.
module pwm_capture #(
  parameter int N           = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pwm_in,
  output logic [N-1:0] sample_out,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         locked,
  output logic         sync_err,
  output logic         overrun
);

  localparam logic [0:0]   ACQUIRE = 1'b0;
  localparam logic [0:0]   TRACK   = 1'b1;
  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise;
  logic [0:0]             state;
  logic [N-1:0]           frm_cnt, hi_cnt, result;
  logic                   close, resync, emit;

  assign s      = sync_q[SYNC_STAGES-1];
  assign locked = (state == TRACK);

  // Synchroniser chain and one-clock delay of its output for edge detect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  // Frame-close detection, realignment decision and emit decision.
  always_comb begin
    rise   = s & ~s_d;
    close  = (frm_cnt == CNT_MAX);
    // result includes the current clock's level, saturating at 2^N-1
    result = (hi_cnt == CNT_MAX) ? CNT_MAX : hi_cnt + {{(N-1){1'b0}}, s};
    // In ACQUIRE any rise aligns; in TRACK only a rise off frame start does.
    resync = (state == ACQUIRE) ? rise : (rise && (frm_cnt != '0));
    // Unlocked, only an all-low frame is reportable (duty 0 looks like idle).
    emit   = close && !rise && ((state == TRACK) || (result == '0));
  end

  // Frame/high counters and alignment state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ACQUIRE;
      frm_cnt <= '0;
      hi_cnt  <= '0;
    end else if (resync) begin
      // the rise clock itself is the first high clock of the new frame
      state   <= TRACK;
      frm_cnt <= CNT_ONE;
      hi_cnt  <= CNT_ONE;
    end else if (close) begin
      frm_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      frm_cnt <= frm_cnt + CNT_ONE;
      hi_cnt  <= result;
    end
  end

  // Output register, handshake and status pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sync_err     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sync_err <= resync && (state == TRACK);
      overrun  <= 1'b0;
      if (emit) begin
        // ready on the same edge means the old sample was taken: no overrun
        sample_out   <= result;
        sample_valid <= 1'b1;
        overrun      <= sample_valid & ~sample_ready;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives a model PWM transmitter (plus glitches) into
// pwm_capture and checks every output on every cycle against a frame-level
// model: sample = popcount of the last 2^N synchronised line values.
module tb_pwm_capture;
  localparam int N    = 10;
  localparam int SS   = 2;
  localparam int FR   = 1 << N;
  localparam int MAXV = FR - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         pwm_in = 1'b0;
  logic         sample_ready = 1'b0;
  logic [N-1:0] sample_out;
  logic         sample_valid, locked, sync_err, overrun;

  always #5 clk = ~clk;

  pwm_capture #(.N(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .locked(locked),
    .sync_err(sync_err), .overrun(overrun)
  );

  // ---------------- reference model ----------------
  int  kc = 0, rcyc = 0, fs = 1;
  bit  p_hist [4096];
  bit  m_locked, m_valid, m_serr, m_ovr, m_init;
  int  m_out;

  // synchronised line level seen by the receiver at edge k
  function automatic bit s_of(int k);
    if (k <= rcyc + SS) return 1'b0;
    return p_hist[(k - SS) % 4096];
  endfunction

  // high clocks in the 2^N-clock window ending at edge k, saturated
  function automatic int win_count(int k);
    int c = 0;
    for (int j = k - FR + 1; j <= k; j++) c += int'(s_of(j));
    return (c > MAXV) ? MAXV : c;
  endfunction

  // Model: frame position is clocks since the last alignment point.
  always @(posedge clk) begin : model
    int pos, res;
    bit rise, emit;
    kc++;
    p_hist[kc % 4096] = pwm_in;
    if (!reset_n) begin
      rcyc = kc; fs = kc + 1;
      m_locked = 0; m_valid = 0; m_out = 0; m_serr = 0; m_ovr = 0; m_init = 1;
    end else begin
      rise = s_of(kc) && !s_of(kc - 1);
      pos  = (kc - fs) % FR;
      emit = 0; res = 0; m_serr = 0; m_ovr = 0;
      if (!m_locked) begin
        if (rise) begin m_locked = 1; fs = kc; end
        else if (pos == FR - 1) begin res = win_count(kc); emit = (res == 0); end
      end else if (rise && pos != 0) begin
        m_serr = 1; fs = kc;
      end else if (pos == FR - 1) begin
        res = win_count(kc); emit = 1;
      end
      if (emit) begin
        m_ovr = m_valid && !sample_ready; m_out = res; m_valid = 1;
      end else if (m_valid && sample_ready) m_valid = 0;
    end
  end

  // ---------------- stimulus and checking ----------------
  int n_tests = 0, n_fail = 0, n_cyc_fail = 0;
  int tx_cnt = 0, tx_duty = 0, next_duty = 0, inj_at = -1, inj = 0;
  bit rand_rdy = 0, rand_glitch = 0, watch3 = 0, prev_valid = 0;
  int serr_cnt = 0, ovr_cnt = 0, emit_cnt = 0, last_sample = -1, odd_cnt = 0;
  int s0, e0, o0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (m_init) begin
      n_tests++;
      if ({sample_out, sample_valid, locked, sync_err, overrun} !==
          {m_out[N-1:0], m_valid, m_locked, m_serr, m_ovr}) begin
        n_fail++; n_cyc_fail++;
        if (n_cyc_fail <= 20)
          $display("FAIL cycle %0d: dut out=%0d v=%b lk=%b se=%b ov=%b required out=%0d v=%b lk=%b se=%b ov=%b",
                   kc, sample_out, sample_valid, locked, sync_err, overrun,
                   m_out, m_valid, m_locked, m_serr, m_ovr);
      end
    end
    if (sync_err) serr_cnt++;
    if (overrun) ovr_cnt++;
    if (sample_valid && !prev_valid) begin
      emit_cnt++;
      if (watch3 && sample_out != 10'd1023 && sample_out != 10'd5) odd_cnt++;
    end
    if (sample_valid) last_sample = int'(sample_out);
    prev_valid = sample_valid;
    // transmitter: duty latched at frame start
    tx_cnt = (tx_cnt + 1) % FR;
    if (tx_cnt == 0) tx_duty = next_duty;
    if (tx_cnt == inj_at) begin inj = 3; inj_at = -1; end
    if (rand_glitch && $urandom_range(0, 4999) == 0) inj = int'($urandom_range(1, 5));
    pwm_in = (tx_cnt < tx_duty) || (inj > 0);
    if (inj > 0) inj--;
    if (rand_rdy) sample_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(int c);
    int g = 0;
    while (tx_cnt != c && g < 2 * FR) begin step(); g++; end
    if (tx_cnt != c) begin
      n_tests++; n_fail++;
      $display("FAIL run_to: tx_cnt=%0d required %0d", tx_cnt, c);
    end
  endtask

  initial begin
    // reset state
    sample_ready = 1; reset_n = 0;
    run(2);
    check("rst_valid", sample_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_out", sample_out, 0);
    reset_n = 1;

    // 1: duty 300, frames start right after reset
    tx_cnt = FR - 1; tx_duty = 0; next_duty = 300;
    s0 = serr_cnt; e0 = emit_cnt;
    run(5 * FR + 50);
    check("t1_locked", locked, 1);
    check("t1_sample", last_sample, 300);
    check("t1_serr", serr_cnt - s0, 0);
    check("t1_emits", emit_cnt - e0, 5);

    // 2: duty 0 from reset stays unlocked, emits 0 per frame
    tx_duty = 0; next_duty = 0;
    reset_n = 0; step(); reset_n = 1;
    e0 = emit_cnt;
    run(3 * FR + 100);
    check("t2_locked", locked, 0);
    check("t2_emits", emit_cnt - e0, 3);
    check("t2_sample", last_sample, 0);

    // 3: duty 1023 then 5, no intermediate values
    next_duty = 1023;
    run(FR + 10);
    watch3 = 1;
    run(2 * FR);
    next_duty = 5;
    run(4 * FR);
    watch3 = 0;
    check("t3_sample", last_sample, 5);
    check("t3_odd", odd_cnt, 0);
    check("t3_locked", locked, 1);

    // 4: extra 3-clk pulse at tx position 400: realign twice, then recover
    next_duty = 300;
    run(2 * FR);
    s0 = serr_cnt; inj_at = 400;
    run(3 * FR);
    check("t4_serr", serr_cnt - s0, 2);
    check("t4_sample", last_sample, 300);

    // 5: ready low across frames of duty 10/20/30
    run_to(500); next_duty = 10;
    run(1); run_to(500); sample_ready = 0; next_duty = 20; o0 = ovr_cnt;
    run(1); run_to(500); next_duty = 30;
    run(1); run_to(500);
    run(1); run_to(500);
    check("t5_overruns", ovr_cnt - o0, 2);
    check("t5_out", sample_out, 30);
    check("t5_valid", sample_valid, 1);
    sample_ready = 1;
    step();
    check("t5_drop", sample_valid, 0);

    // 6: reset mid-frame, then relock
    next_duty = 300;
    run(2 * FR);
    run_to(600);
    reset_n = 0; step();
    check("t6_out", sample_out, 0);
    check("t6_valid", sample_valid, 0);
    check("t6_locked", locked, 0);
    check("t6_pulses", {sync_err, overrun}, 0);
    reset_n = 1;
    run(3 * FR);
    check("t6_relock", locked, 1);
    check("t6_sample", last_sample, 300);

    // 7: random duties, random ready, occasional glitches
    rand_rdy = 1; rand_glitch = 1;
    for (int f = 0; f < 15; f++) begin
      next_duty = int'($urandom_range(0, MAXV));
      run(FR);
    end
    rand_rdy = 0; rand_glitch = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
